// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ALU function codes and branch/cmov condition codes.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

endpackage

// File: rtl/alu_64bit.sv
// Combinational 64-bit Y86 ALU: b+a, b-a, a&b, a^b with signed-overflow flag.
module alu_64bit
  import y86_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_fn_e     fn,
  output logic [63:0] result,
  output logic        ovf
);

  always_comb begin
    result = 64'd0;
    ovf    = 1'b0;
    unique case (fn)
      ALU_ADD: begin
        result = b + a;
        ovf    = (a[63] == b[63]) && (result[63] != a[63]);
      end
      ALU_SUB: begin
        result = b - a;
        ovf    = (a[63] != b[63]) && (result[63] != b[63]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register and branch/cmov condition, one-cycle latency.
// Optional stall input enabled by defining EXE_STALL_EN.
module execute_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  input  logic        cc_en,
`ifdef EXE_STALL_EN
  input  logic        stall,
`endif
  output logic        out_valid,
  output logic [63:0] val_e,
  output logic        cnd,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  logic        out_valid_q, out_valid_d;
  logic [63:0] val_e_q, val_e_d;
  logic        cnd_q, cnd_d;
  logic        zf_q, zf_d;
  logic        sf_q, sf_d;
  logic        of_q, of_d;

  logic        is_opq;
  logic        fn_ok;
  logic        cc_wr;
  alu_fn_e     alu_fn;
  logic [63:0] alu_result;
  logic        alu_ovf;

  function automatic logic cond_eval(input logic [3:0] fn, input logic z, input logic s,
                                     input logic o);
    logic lt;
    lt = s ^ o;
    case (fn)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | z;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = z;
      C_NE:     cond_eval = !z;
      C_GE:     cond_eval = !lt;
      C_G:      cond_eval = !lt && !z;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

  assign is_opq = (icode == OPQ);
  assign fn_ok  = (ifun[3:2] == 2'b00);
  assign alu_fn = is_opq ? alu_fn_e'(ifun[1:0]) : ALU_ADD;
  assign cc_wr  = in_valid && is_opq && fn_ok && cc_en;

  alu_64bit u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  always_comb begin
    out_valid_d = in_valid;
    val_e_d     = 64'd0;
    cnd_d       = 1'b0;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    if (in_valid) begin
      val_e_d = (is_opq && !fn_ok) ? 64'd0 : alu_result;
      // Conditions see the flags held before this instruction's own CC update.
      if (icode == CMOVXX || icode == JXX)
        cnd_d = cond_eval(ifun, zf_q, sf_q, of_q);
    end
    if (cc_wr) begin
      zf_d = (alu_result == 64'd0);
      sf_d = alu_result[63];
      of_d = alu_ovf;
    end
`ifdef EXE_STALL_EN
    if (stall) begin
      out_valid_d = out_valid_q;
      val_e_d     = val_e_q;
      cnd_d       = cnd_q;
      zf_d        = zf_q;
      sf_d        = sf_q;
      of_d        = of_q;
    end
`endif
  end

  // Stage boundary: execute -> memory
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      val_e_q     <= 64'd0;
      cnd_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      val_e_q     <= val_e_d;
      cnd_q       <= cnd_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end

  assign out_valid = out_valid_q;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed steps plus random traffic against a behavioural model.
// Stall scenarios are exercised when EXE_STALL_EN is defined.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        cc_en;
  logic        stall;
  logic        out_valid;
  logic [63:0] val_e;
  logic        cnd;
  logic        zf, sf, of;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_vld;
  logic [63:0] m_val;
  logic        m_cnd;
  logic        m_zf, m_sf, m_of;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .icode     (icode),
    .ifun      (ifun),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .cc_en     (cc_en),
`ifdef EXE_STALL_EN
    .stall     (stall),
`endif
    .out_valid (out_valid),
    .val_e     (val_e),
    .cnd       (cnd),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, using the pre-edge flags for conditions.
  task automatic model_edge(input logic rst, input logic iv, input logic [3:0] ic,
                            input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                            input logic ce, input logic st);
    logic signed [64:0] exact;
    logic [63:0] res;
    logic        ovf, c, lt, writes;
    if (rst) begin
      m_vld = 0; m_val = 0; m_cnd = 0; m_zf = 1; m_sf = 0; m_of = 0;
      return;
    end
    if (st) return;
    res = 0; ovf = 0; c = 0; exact = 0;
    lt = (m_sf != m_of);
    if (iv && (ic == 4'd2 || ic == 4'd7)) begin
      if (fn == 0) c = 1;
      else if (fn == 1) c = lt || m_zf;
      else if (fn == 2) c = lt;
      else if (fn == 3) c = m_zf;
      else if (fn == 4) c = !m_zf;
      else if (fn == 5) c = !lt;
      else if (fn == 6) c = !lt && !m_zf;
    end
    if (iv) begin
      if (ic == 4'd6) begin
        if (fn == 0) begin
          res = b + a;
          exact = $signed({b[63], b}) + $signed({a[63], a});
          ovf = (exact != $signed({res[63], res}));
        end else if (fn == 1) begin
          res = b - a;
          exact = $signed({b[63], b}) - $signed({a[63], a});
          ovf = (exact != $signed({res[63], res}));
        end else if (fn == 2) res = a & b;
        else if (fn == 3) res = a ^ b;
      end else begin
        res = a + b;
      end
    end
    writes = iv && ic == 4'd6 && fn <= 3 && ce;
    m_vld = iv;
    m_val = res;
    m_cnd = c;
    if (writes) begin
      m_zf = (res == 0);
      m_sf = res[63];
      m_of = ovf;
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic ce,
                      input logic st, input string tag);
    reset = rst; in_valid = iv; icode = ic; ifun = fn;
    alu_a = a; alu_b = b; cc_en = ce; stall = st;
    @(posedge clk);
    model_edge(rst, iv, ic, fn, a, b, ce, st);
    #1;
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_vld});
    check({tag, ".val_e"}, val_e, m_val);
    check({tag, ".cnd"}, {63'd0, cnd}, {63'd0, m_cnd});
    check({tag, ".zf"}, {63'd0, zf}, {63'd0, m_zf});
    check({tag, ".sf"}, {63'd0, sf}, {63'd0, m_sf});
    check({tag, ".of"}, {63'd0, of}, {63'd0, m_of});
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: rand_operand = 64'd0;
      1: rand_operand = 64'h7FFF_FFFF_FFFF_FFFF;
      2: rand_operand = 64'h8000_0000_0000_0000;
      3: rand_operand = 64'hFFFF_FFFF_FFFF_FFFF;
      default: rand_operand = {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    reset = 1; in_valid = 0; icode = 0; ifun = 0; alu_a = 0; alu_b = 0; cc_en = 1; stall = 0;
    m_vld = 0; m_val = 0; m_cnd = 0; m_zf = 1; m_sf = 0; m_of = 0;

    step(1, 1, 4'd6, 4'd0, 64'd7, 64'd9, 1, 0, "reset");
    // Literal reset values, independent of the model
    check("reset_zf_literal", {63'd0, zf}, 64'd1);
    check("reset_val_literal", val_e, 64'd0);
    step(0, 0, 4'd0, 4'd0, 64'd0, 64'd0, 1, 0, "idle");
    step(0, 1, 4'd7, 4'd3, 64'd0, 64'd0, 1, 0, "je_after_reset");
    check("je_after_reset_literal", {63'd0, cnd}, 64'd1);

    step(0, 1, 4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, "add_ovf");
    check("add_ovf_val_literal", val_e, 64'h8000_0000_0000_0000);
    check("add_ovf_of_literal", {63'd0, of}, 64'd1);
    step(0, 1, 4'd7, 4'd2, 64'd0, 64'd0, 1, 0, "jl_after_add");
    check("jl_after_add_literal", {63'd0, cnd}, 64'd0);

    step(0, 1, 4'd6, 4'd1, 64'd5, 64'd5, 1, 0, "sub_zero");
    step(0, 1, 4'd2, 4'd1, 64'd0, 64'd0, 1, 0, "cmovle");
    check("cmovle_literal", {63'd0, cnd}, 64'd1);
    step(0, 1, 4'd2, 4'd6, 64'd0, 64'd0, 1, 0, "cmovg");

    step(0, 1, 4'd6, 4'd3, 64'hFF, 64'hFF, 0, 0, "xor_cc_blocked");
    step(0, 0, 4'd6, 4'd3, 64'hFF, 64'hFF, 1, 0, "xor_bubble");
    step(0, 1, 4'd4, 4'd0, 64'd16, 64'h100, 1, 0, "rmmovq");
    check("rmmovq_literal", val_e, 64'h110);
    step(0, 1, 4'd6, 4'd5, 64'd3, 64'd4, 1, 0, "opq_bad_fn");
    step(0, 1, 4'd6, 4'd1, 64'h8000_0000_0000_0000, 64'd0, 1, 0, "sub_ovf");
    step(0, 1, 4'd7, 4'd5, 64'd0, 64'd0, 1, 0, "jge_after_sub_ovf");
    step(1, 1, 4'd6, 4'd1, 64'd1, 64'd0, 1, 0, "reset_midstream");

`ifdef EXE_STALL_EN
    step(0, 1, 4'd6, 4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "add_before_stall");
    step(0, 1, 4'd6, 4'd0, 64'd3, 64'd4, 1, 1, "stall1");
    step(0, 1, 4'd6, 4'd0, 64'd3, 64'd4, 1, 1, "stall2");
    step(0, 1, 4'd6, 4'd0, 64'd3, 64'd4, 1, 0, "after_stall");
    step(0, 1, 4'd6, 4'd1, 64'd9, 64'd2, 1, 1, "stall_pre_reset");
    step(1, 1, 4'd6, 4'd1, 64'd9, 64'd2, 1, 1, "reset_in_stall");
`endif

    for (int i = 0; i < 300; i++) begin
      logic [3:0] ic;
      logic       st;
      case ($urandom_range(0, 4))
        0: ic = 4'd2;
        1: ic = 4'd7;
        2, 3: ic = 4'd6;
        default: ic = 4'($urandom_range(0, 15));
      endcase
`ifdef EXE_STALL_EN
      st = ($urandom_range(0, 7) == 0);
`else
      st = 1'b0;
`endif
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0), ic,
           4'($urandom_range(0, 7)), rand_operand(), rand_operand(),
           ($urandom_range(0, 5) != 0), st, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Y86-64 pipeline execute stage. It consumes the operands selected by decode, drives the 64-bit ALU (add/sub/and/xor), and holds the architectural condition-code register (ZF, SF, OF). It evaluates branch/cmov conditions and registers valE, Cnd and a valid flag for the memory stage. Latency is one cycle.

## Interface
- No parameters; datapath width is fixed at 64.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present (0 = bubble)
- icode  in  4  Y86 icode
- ifun  in  4  Y86 ifun
- alu_a  in  64  ALU operand A (valA/valC/±8, selected upstream)
- alu_b  in  64  ALU operand B (valB or 0, selected upstream)
- cc_en  in  1  0 when a later stage holds an exception; blocks CC writes
- stall  in  1  present only with EXE_STALL_EN
- out_valid  out  1  registered valid to memory stage
- val_e  out  64  registered ALU result
- cnd  out  1  registered condition result
- zf, sf, of  out  1 each  current CC register

## Operation
- ALU function:
  - If icode==OPQ(6), use ifun: 0 add → alu_b+alu_a; 1 sub → alu_b−alu_a; 2 and; 3 xor.
  - Any other icode is an add.
  - OPQ with ifun>3: val_e=0, CC not written, out_valid still follows in_valid.
- Arithmetic is modulo 2^64 with no carry output.
- Overflow:
  - add: sign(a)==sign(b) and sign(result)≠sign(a).
  - sub: sign(a)≠sign(b) and sign(result)≠sign(b).
  - and/xor: OF=0.
- CC write: only when in_valid && icode==OPQ && ifun≤3 && cc_en.
  - ZF = result==0; SF = result[63]; OF as above.
- cnd is computed from the CC value held *before* this cycle's update. Evaluated only for icode CMOVXX(2) or JXX(7); otherwise 0.
  - ifun 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → !ZF
  - 5 ge → !(SF^OF)
  - 6 g → !(SF^OF)&!ZF
  - ifun>6 → 0
- Bubble (in_valid=0): out_valid←0, val_e←0, cnd←0, CC held.

## Timing
- Reset values: out_valid=0, val_e=0, cnd=0, zf=1, sf=0, of=0.
- Edge N samples the inputs; val_e, cnd and out_valid appear after edge N.
- The CC update is visible on zf/sf/of after the same edge.
- Back-to-back case: an OPQ in cycle N followed by a JXX in cycle N+1 sees the OPQ's flags. No internal forwarding is needed.
- Reset asserted mid-stream clears all registers at that edge, overriding in_valid, cc_en and stall.

## Configuration
- EXE_STALL_EN defined:
  - stall port exists.
  - stall=1 holds out_valid, val_e, cnd and CC, and ignores inputs that cycle.
  - Reset beats stall.
- EXE_STALL_EN undefined:
  - No stall port.
  - The stage advances every cycle.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT…POPQ; CMOVXX=2, OPQ=6, JXX=7)
  - ALU ifun constants (ALU_ADD..ALU_XOR)
  - condition ifun constants (C_ALWAYS..C_G)
- One combinational sub-module, alu_64bit:
  - inputs a, b, fn
  - outputs result, ovf
  - instantiated once
- Condition evaluation and the registers live in execute_stage.

## Test plan
- Reset, then idle:
  - outputs 0, zf=1, sf=0, of=0
  - icode=JXX, ifun=3 (e) → cnd=1
- OPQ add, a=1, b=0x7FFF_FFFF_FFFF_FFFF:
  - val_e=0x8000_0000_0000_0000
  - zf=0, sf=1, of=1
  - next JXX ifun=2 (l) → cnd=0
- OPQ sub, a=5, b=5:
  - val_e=0, zf=1, sf=0, of=0
  - following CMOVXX ifun=1 (le) → cnd=1
  - following ifun=6 (g) → cnd=0
- OPQ xor, a=b=0xFF, cc_en=0:
  - val_e=0, CC unchanged from the previous instruction
  - same with in_valid=0 → out_valid=0, CC unchanged
- Non-OPQ icode RMMOVQ(4), a=16, b=0x100:
  - val_e=0x110, CC unchanged, cnd=0
- With EXE_STALL_EN:
  - stall=1 for 2 cycles during an OPQ add → outputs and CC frozen
  - reset during stall → reset values next cycle
